puf_iq_framer: RTL and testbench
================================

// Module: puf_iq_framer
// PURPOSE
//  Buffers the bursty, unframed IQ stream from the PUF capture front end in a small
//  FIFO and emits it as fixed-length AXI-stream packets with out_tlast on the last sample.
//  Sits directly upstream of the PUF-to-USRP linear interpolator. Packets leave as one
//  gap-free burst, so the interpolator never sees a mid-packet in_tvalid drop.
//  A stalled source is flushed as a short packet after an idle timeout.
// PARAMETERS
//  DATA_WIDTH    16  width of each of I and Q; a sample is 2*DATA_WIDTH bits, I in the upper half
//  FIFO_AW       6   FIFO address width; DEPTH = 2**FIFO_AW samples
//  PKT_LEN       32  samples per full packet; legal range 1..DEPTH
//  IDLE_TIMEOUT  64  idle cycles before a partial packet is flushed; 0 disables the flush
// PORTS
//  clk         in   1             clock
//  reset       in   1             asynchronous, active-low reset
//  in_tdata    in   2*DATA_WIDTH  IQ sample {I,Q}
//  in_tvalid   in   1             input sample valid
//  in_tready   out  1             input ready; equals (level < DEPTH)
//  out_tdata   out  2*DATA_WIDTH  IQ sample to the interpolator
//  out_tvalid  out  1             output valid
//  out_tlast   out  1             last sample of the packet
//  out_tready  in   1             downstream ready
//  fifo_level  out  FIFO_AW+1     current FIFO occupancy
// BEHAVIOUR
//  Reset (reset==0, takes effect immediately):
//   - Pointers, level, counters and FSM go to IDLE.
//   - in_tready=0 while reset is low, =1 from the first cycle after release.
//   - out_tvalid=0, out_tlast=0, fifo_level=0.
//   - Reset mid-packet abandons all buffered data; no partial tlast is produced.
//  FIFO:
//   - Write on in_tvalid&in_tready. Read on out_tvalid&out_tready in SEND/SHORT.
//   - out_tdata = mem[rd_ptr] (asynchronous read).
//   - Pointers wrap modulo DEPTH. A simultaneous read and write leaves level unchanged.
//   - Full: in_tready=0 and no data is lost (backpressure only). Empty: no read occurs.
//  FSM (out_tvalid = state in {SEND,SHORT,PAD}):
//   - IDLE: if level>=PKT_LEN, go to SEND with pkt_cnt=0. Else, if the idle timer has
//     expired, latch rem=level and go to SHORT. A full packet has priority over the timeout.
//   - SEND: each beat increments pkt_cnt. out_tlast=(pkt_cnt==PKT_LEN-1). The last
//     accepted beat returns the FSM to IDLE.
//   - SHORT: emits exactly rem samples; out_tlast is high on the rem-th beat. Samples
//     written during SHORT are not included (rem is fixed at latch time).
//  Idle timer:
//   - Counts only in IDLE with 0<level<PKT_LEN and no write this cycle.
//   - Clears on any write, when level==0, or when outside IDLE.
//   - Expires when the count reaches IDLE_TIMEOUT-1.
//  Latency:
//   - The write edge that makes level>=PKT_LEN moves the FSM out of IDLE on the next edge.
//   - out_tvalid goes high in the cycle after that edge.
//   - A packet streams at 1 sample/cycle while out_tready=1. out_tready low holds
//     out_tdata and out_tlast stable.
//   - There is one dead cycle (IDLE) between back-to-back packets.
// CONFIGURATION
//  PUF_FRAMER_PAD_EN
//   - Defined: after the rem-th beat, SHORT goes to PAD instead of IDLE.
//     out_tlast is low on the rem-th beat. PAD emits PKT_LEN-rem beats of out_tdata=0,
//     with no FIFO reads and out_tlast on the final beat, then returns to IDLE.
//     Every packet is then exactly PKT_LEN samples long.
//   - Undefined: PAD does not exist and short packets end with out_tlast on sample rem.
// TESTING
//  1. Reset release, then 32 contiguous samples 0..31 with out_tready=1 -> one packet
//     0..31, tlast only on 31, out_tvalid first high 2 cycles after the write of 31.
//  2. out_tready=0, write 70 samples -> in_tready drops after 64 with fifo_level=64;
//     then out_tready=1 -> two packets of 32, remaining 6 accepted, none lost.
//  3. Write 10 samples, then idle 64 cycles -> short packet of 10 with tlast on the 10th
//     (undefined macro); with PUF_FRAMER_PAD_EN, 10 data + 22 zeros, tlast on the 32nd.
//  4. During a SEND with out_tready toggling every cycle, write concurrently -> order
//     preserved, fifo_level is correct on simultaneous read/write, tdata is stable while
//     stalled.
//  5. Assert reset mid-packet after 12 beats -> out_tvalid=0 immediately, fifo_level=0;
//     the next 32 samples form a clean packet.
//  6. IDLE_TIMEOUT=0, write 5 samples and wait 1000 cycles -> no output; 27 more samples
//     -> one 32-sample packet.

Source files
------------

// File: rtl/puf_iq_framer_if.sv
// Stream bundle for puf_iq_framer: unframed IQ input, packetised IQ output, FIFO level.
// slave is the framer side, master is the source/sink side.
interface puf_iq_framer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_AW    = 6
);
  logic [2*DATA_WIDTH-1:0] in_tdata;
  logic                    in_tvalid;
  logic                    in_tready;
  logic [2*DATA_WIDTH-1:0] out_tdata;
  logic                    out_tvalid;
  logic                    out_tlast;
  logic                    out_tready;
  logic [FIFO_AW:0]        fifo_level;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast, fifo_level
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast, fifo_level
  );
endinterface

// File: rtl/puf_iq_framer.sv
// IQ framer: FIFO-buffers a bursty IQ stream and emits gap-free fixed-length packets,
// flushing a stalled partial packet after an idle timeout. Macro PUF_FRAMER_PAD_EN zero-pads flushes.
module puf_iq_framer #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_AW      = 6,
  parameter int PKT_LEN      = 32,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  puf_iq_framer_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam logic [FIFO_AW:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [FIFO_AW:0] PKT_L    = LW'(PKT_LEN);
  localparam logic [FIFO_AW:0] PKT_LAST = LW'(PKT_LEN - 1);
  localparam logic [31:0]      TO_LAST  = 32'(IDLE_TIMEOUT - 1);

`ifdef PUF_FRAMER_PAD_EN
  typedef enum logic [1:0] {IDLE, SEND, SHORT, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, SHORT} state_t;
`endif

  state_t                  state_q;
  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]        level_q, pkt_cnt_q, rem_q;
  logic [31:0]             idle_cnt_q;
  logic                    ready_en_q;
  logic                    wr_en, rd_en, timer_exp, pkt_end, short_end;

  assign bus.in_tready  = ready_en_q && (level_q < DEPTH_L);
  assign bus.out_tvalid = (state_q != IDLE);
  assign bus.fifo_level = level_q;

  assign wr_en     = bus.in_tvalid && bus.in_tready;
  assign rd_en     = bus.out_tready && ((state_q == SEND) || (state_q == SHORT)) && (level_q != '0);
  assign pkt_end   = (pkt_cnt_q == PKT_LAST);
  assign short_end = (pkt_cnt_q == rem_q - 1'b1);
  assign timer_exp = (IDLE_TIMEOUT != 0) && (idle_cnt_q == TO_LAST) && (level_q != '0);

`ifdef PUF_FRAMER_PAD_EN
  // Padding beats continue the beat count from rem, so tlast lands on beat PKT_LEN.
  assign bus.out_tdata = (state_q == PAD) ? '0 : mem_q[rd_ptr_q];
  assign bus.out_tlast = ((state_q == SEND) || (state_q == PAD)) && pkt_end;
`else
  assign bus.out_tdata = mem_q[rd_ptr_q];
  assign bus.out_tlast = ((state_q == SEND) && pkt_end) || ((state_q == SHORT) && short_end);
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.in_tdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // The timer only runs while a partial packet sits untouched in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else if ((state_q == IDLE) && (level_q != '0) && (level_q < PKT_L) && !wr_en) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pkt_cnt_q <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pkt_cnt_q <= '0;
          if (level_q >= PKT_L) begin
            state_q <= SEND;
          end else if (timer_exp) begin
            rem_q   <= level_q;
            state_q <= SHORT;
          end
        end
        SEND: begin
          if (bus.out_tready) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (pkt_end) state_q <= IDLE;
          end
        end
        SHORT: begin
          if (bus.out_tready) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
`ifdef PUF_FRAMER_PAD_EN
            if (short_end) state_q <= PAD;
`else
            if (short_end) state_q <= IDLE;
`endif
          end
        end
`ifdef PUF_FRAMER_PAD_EN
        PAD: begin
          if (bus.out_tready) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (pkt_end) state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_iq_framer.sv
// Self-checking bench for puf_iq_framer: directed steps with random sample data,
// expected packets derived from the framing rules (full packets, then one flushed remainder).
module tb_puf_iq_framer;
  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int PKT = 32;
  localparam int TO  = 64;
  localparam int SW  = 2 * DW;

  typedef logic [SW:0] beat_t;
  typedef struct {
    int    kind;
    beat_t obs;
    beat_t expv;
  } mon_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  beat_t rx[$];
  beat_t rx0[$];
  beat_t exp_q[$];
  mon_t  mq[$];
  int    mi = 0;
  logic  lvl_chk_en = 1'b0;
  logic  toggle_en = 1'b0;
  logic  rdy_cmd = 1'b0;
  logic  tog = 1'b0;
  int    wr_cnt = 0;
  int    rd_cnt = 0;
  logic  stall_q = 1'b0;
  beat_t stall_beat = '0;

  always #5 clk = ~clk;

  puf_iq_framer_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus ();
  puf_iq_framer_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus0 ();

  puf_iq_framer #(.DATA_WIDTH(DW), .FIFO_AW(AW), .PKT_LEN(PKT), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  puf_iq_framer #(.DATA_WIDTH(DW), .FIFO_AW(AW), .PKT_LEN(PKT), .IDLE_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  assign bus.out_tready = toggle_en ? tog : rdy_cmd;
  always @(negedge clk) tog <= ~tog;

  // Monitor samples mid-cycle; it only records, all checking happens in the main sequence.
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset) begin
      stall_q = 1'b0;
      wr_cnt  = 0;
      rd_cnt  = 0;
    end else begin
      if (stall_q && bus.out_tvalid)
        mq.push_back('{1, {bus.out_tlast, bus.out_tdata}, stall_beat});
      if (lvl_chk_en) begin
        mq.push_back('{0, beat_t'(bus.fifo_level), beat_t'(wr_cnt - rd_cnt)});
        if (bus.in_tvalid && bus.in_tready) wr_cnt++;
        if (bus.out_tvalid && bus.out_tready) rd_cnt++;
      end else begin
        wr_cnt = 0;
        rd_cnt = 0;
      end
      stall_q    = bus.out_tvalid && !bus.out_tready;
      stall_beat = {bus.out_tlast, bus.out_tdata};
      if (bus.out_tvalid && bus.out_tready) rx.push_back({bus.out_tlast, bus.out_tdata});
      if (bus0.out_tvalid && bus0.out_tready) rx0.push_back({bus0.out_tlast, bus0.out_tdata});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed time limit reached, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input beat_t obs, input beat_t expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic flush_mon();
    while (mi < mq.size()) begin
      if (mq[mi].kind == 0) chk("fifo_level_track", mq[mi].obs, mq[mi].expv);
      else                  chk("stall_hold", mq[mi].obs, mq[mi].expv);
      mi++;
    end
  endtask

  // Expected output for a source that stops: whole packets first, then one flushed remainder.
  function automatic void build_exp(input logic [SW-1:0] s[$]);
    int n    = s.size();
    int full = (n / PKT) * PKT;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic last;
      if (i < full) begin
        last = ((i % PKT) == PKT - 1);
      end else begin
`ifdef PUF_FRAMER_PAD_EN
        last = 1'b0;
`else
        last = (i == n - 1);
`endif
      end
      exp_q.push_back({last, s[i]});
    end
`ifdef PUF_FRAMER_PAD_EN
    if (n > full)
      for (int j = n - full; j < PKT; j++) exp_q.push_back({(j == PKT - 1), {SW{1'b0}}});
`endif
  endfunction

  task automatic compare_stream(input string tag, input beat_t got[$], input int base);
    $display("stream %s: %0d beats observed, %0d expected", tag, got.size() - base, exp_q.size());
    chk({tag, "_len"}, beat_t'(got.size() - base), beat_t'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      chk(tag, got[base + i], exp_q[i]);
      if (got[base + i] !== exp_q[i]) break;
    end
  endtask

  task automatic send(input logic [SW-1:0] d);
    int w = 0;
    bus.in_tdata  = d;
    bus.in_tvalid = 1'b1;
    while (!bus.in_tready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("send_accept", beat_t'(bus.in_tready), beat_t'(1));
    @(negedge clk);
    bus.in_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int max_cyc);
    int c = 0;
    while (rx.size() < target && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [SW-1:0] s[$];
    logic [SW-1:0] d;
    int base;
    int c;

    bus.in_tdata   = '0;
    bus.in_tvalid  = 1'b0;
    bus0.in_tdata  = '0;
    bus0.in_tvalid = 1'b0;
    bus0.out_tready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_tready", beat_t'(bus.in_tready), beat_t'(0));
    chk("rst_out_tvalid", beat_t'(bus.out_tvalid), beat_t'(0));
    chk("rst_out_tlast", beat_t'(bus.out_tlast), beat_t'(0));
    chk("rst_fifo_level", beat_t'(bus.fifo_level), beat_t'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_tready", beat_t'(bus.in_tready), beat_t'(1));

    // 1: samples 0..31 contiguous, check packet and latency
    rdy_cmd = 1'b1;
    base = rx.size();
    s.delete();
    for (int i = 0; i < PKT; i++) begin
      s.push_back(SW'(i));
      send(SW'(i));
    end
    chk("t1_tvalid_before", beat_t'(bus.out_tvalid), beat_t'(0));
    @(negedge clk);
    chk("t1_tvalid_latency", beat_t'(bus.out_tvalid), beat_t'(1));
    build_exp(s);
    wait_rx(base + exp_q.size(), 300);
    compare_stream("t1_pkt", rx, base);
    chk("t1_level_empty", beat_t'(bus.fifo_level), beat_t'(0));

    // 2: fill to full with the sink stalled, then drain
    rdy_cmd = 1'b0;
    base = rx.size();
    s.delete();
    for (int i = 0; i < 64; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    chk("t2_full_ready", beat_t'(bus.in_tready), beat_t'(0));
    chk("t2_full_level", beat_t'(bus.fifo_level), beat_t'(64));
    repeat (4) @(negedge clk);
    chk("t2_hold_level", beat_t'(bus.fifo_level), beat_t'(64));
    chk("t2_hold_tvalid", beat_t'(bus.out_tvalid), beat_t'(1));
    rdy_cmd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    build_exp(s);
    wait_rx(base + exp_q.size(), 1000);
    compare_stream("t2_stream", rx, base);
    chk("t2_level_empty", beat_t'(bus.fifo_level), beat_t'(0));

    // 3: partial packet flushed after the idle timeout
    base = rx.size();
    s.delete();
    for (int i = 0; i < 10; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    repeat (40) @(negedge clk);
    chk("t3_no_early_flush", beat_t'(rx.size() - base), beat_t'(0));
    chk("t3_level", beat_t'(bus.fifo_level), beat_t'(10));
    build_exp(s);
    wait_rx(base + exp_q.size(), 300);
    compare_stream("t3_short", rx, base);

    // 4: toggling out_tready with concurrent writes
    base = rx.size();
    s.delete();
    toggle_en  = 1'b1;
    lvl_chk_en = 1'b1;
    for (int i = 0; i < PKT; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    for (int i = 0; i < 40; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    lvl_chk_en = 1'b0;
    build_exp(s);
    wait_rx(base + exp_q.size(), 1500);
    compare_stream("t4_stream", rx, base);
    toggle_en = 1'b0;
    flush_mon();

    // 5: reset after 12 beats of a packet
    base = rx.size();
    s.delete();
    for (int i = 0; i < PKT; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    c = 0;
    while (rx.size() < base + 12 && c < 300) begin
      @(negedge clk);
      c++;
    end
    reset = 1'b0;
    #1;
    chk("t5_rst_tvalid", beat_t'(bus.out_tvalid), beat_t'(0));
    chk("t5_rst_tlast", beat_t'(bus.out_tlast), beat_t'(0));
    chk("t5_rst_level", beat_t'(bus.fifo_level), beat_t'(0));
    chk("t5_rst_ready", beat_t'(bus.in_tready), beat_t'(0));
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, s[i]});
    compare_stream("t5_abandoned", rx, base);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = rx.size();
    s.delete();
    for (int i = 0; i < PKT; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      send(d);
    end
    build_exp(s);
    wait_rx(base + exp_q.size(), 300);
    compare_stream("t5_clean", rx, base);

    // 6: timeout disabled instance never flushes
    base = rx0.size();
    s.delete();
    bus0.out_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      bus0.in_tdata  = d;
      bus0.in_tvalid = 1'b1;
      chk("t6_ready", beat_t'(bus0.in_tready), beat_t'(1));
      @(negedge clk);
    end
    bus0.in_tvalid = 1'b0;
    repeat (1000) @(negedge clk);
    chk("t6_no_flush", beat_t'(rx0.size() - base), beat_t'(0));
    chk("t6_level", beat_t'(bus0.fifo_level), beat_t'(5));
    for (int i = 0; i < 27; i++) begin
      d = SW'($urandom);
      s.push_back(d);
      bus0.in_tdata  = d;
      bus0.in_tvalid = 1'b1;
      chk("t6_ready", beat_t'(bus0.in_tready), beat_t'(1));
      @(negedge clk);
    end
    bus0.in_tvalid = 1'b0;
    build_exp(s);
    c = 0;
    while (rx0.size() < base + exp_q.size() && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
    compare_stream("t6_pkt", rx0, base);

    flush_mon();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
